// File: rtl/rl_step_sequencer.sv
// rl_step_sequencer
//   Episode/step controller for the traffic-light learning accelerator.
//   One step: snapshot lane levels, ask the agent for an action, hold it as
//   the light phase for HOLD_CYCLES, re-snapshot the levels, wait one cycle
//   for the reward decider to register its reward, capture that reward into
//   a saturating episode accumulator, then hand it to the Q-updater.
//   After MAX_STEPS completed steps the episode ends with a one-cycle pulse.
//
// Handshakes (act_req/act_ack, upd_req/upd_done): the request is a level that
//   stays high from the first cycle of its state until the cycle in which the
//   acknowledge is sampled high on a rising edge; acknowledge in the first
//   request cycle is accepted, acknowledges outside that state are ignored,
//   and abort in the same cycle wins over the acknowledge.
//
// Ports:
//   clk, rst            clock, asynchronous active-high reset
//   start, abort        episode start pulse, synchronous abort
//   L0..L3              live lane queue levels
//   L0_s..L3_s          registered level snapshot for the reward decider
//   act_req/act_ack     action request / acknowledge, action valid with ack
//   action, phase       agent action in, applied light phase out
//   R_in, R_out         reward from decider, captured step reward out
//   upd_req/upd_done    Q-update request / completion
//   step_cnt            completed steps in the current episode
//   ep_reward           saturating signed episode reward
//   busy, episode_done  not-idle flag, end-of-episode pulse
//   state_dbg           current FSM state (debug visibility)

module rl_step_sequencer #(
  parameter int L_WIDTH     = 4,
  parameter int R_WIDTH     = 16,
  parameter int A_WIDTH     = 2,
  parameter int ACC_WIDTH   = 24,
  parameter int HOLD_CYCLES = 8,
  parameter int MAX_STEPS   = 16,
  parameter int STEP_WIDTH  = 8
) (
  input  logic                        clk,
  input  logic                        rst,
  input  logic                        start,
  input  logic                        abort,
  input  logic [L_WIDTH-1:0]          L0,
  input  logic [L_WIDTH-1:0]          L1,
  input  logic [L_WIDTH-1:0]          L2,
  input  logic [L_WIDTH-1:0]          L3,
  output logic [L_WIDTH-1:0]          L0_s,
  output logic [L_WIDTH-1:0]          L1_s,
  output logic [L_WIDTH-1:0]          L2_s,
  output logic [L_WIDTH-1:0]          L3_s,
  output logic                        act_req,
  input  logic                        act_ack,
  input  logic [A_WIDTH-1:0]          action,
  output logic [A_WIDTH-1:0]          phase,
  input  logic signed [R_WIDTH-1:0]   R_in,
  output logic signed [R_WIDTH-1:0]   R_out,
  output logic                        upd_req,
  input  logic                        upd_done,
  output logic [STEP_WIDTH-1:0]       step_cnt,
  output logic signed [ACC_WIDTH-1:0] ep_reward,
  output logic                        busy,
  output logic                        episode_done,
  output logic [3:0]                  state_dbg
);

  localparam logic [3:0] S_IDLE     = 4'd0;
  localparam logic [3:0] S_SENSE    = 4'd1;
  localparam logic [3:0] S_ACT      = 4'd2;
  localparam logic [3:0] S_HOLD     = 4'd3;
  localparam logic [3:0] S_RESAMPLE = 4'd4;
  localparam logic [3:0] S_SETTLE   = 4'd5;
  localparam logic [3:0] S_REWARD   = 4'd6;
  localparam logic [3:0] S_UPDATE   = 4'd7;
  localparam logic [3:0] S_DONE     = 4'd8;

  localparam int HC_W = (HOLD_CYCLES > 1) ? $clog2(HOLD_CYCLES) : 1;
  localparam logic [HC_W-1:0] HOLD_LOAD = HC_W'(HOLD_CYCLES - 1);
  localparam logic [STEP_WIDTH-1:0] MAX_CNT = STEP_WIDTH'(MAX_STEPS);

  // The sum is one bit wider than the wider operand so it can never wrap
  // before the clamp decides.
  localparam int SUM_W = ((ACC_WIDTH > R_WIDTH) ? ACC_WIDTH : R_WIDTH) + 1;
  localparam logic signed [SUM_W-1:0] ACC_MAX =
    {{(SUM_W-ACC_WIDTH+1){1'b0}}, {(ACC_WIDTH-1){1'b1}}};
  localparam logic signed [SUM_W-1:0] ACC_MIN =
    {{(SUM_W-ACC_WIDTH+1){1'b1}}, {(ACC_WIDTH-1){1'b0}}};

  logic [3:0]                  state;
  logic [3:0]                  state_nx;
  logic [HC_W-1:0]             hold_cnt;
  logic [STEP_WIDTH-1:0]       step_inc;
  logic signed [SUM_W-1:0]     acc_ext;
  logic signed [SUM_W-1:0]     r_ext;
  logic signed [SUM_W-1:0]     sum_ext;
  logic signed [ACC_WIDTH-1:0] sum_sat;

  assign step_inc = step_cnt + STEP_WIDTH'(1);

  // Saturating add of the sign-extended reward into the episode sum.
  always_comb begin
    acc_ext = {{(SUM_W-ACC_WIDTH){ep_reward[ACC_WIDTH-1]}}, ep_reward};
    r_ext   = {{(SUM_W-R_WIDTH){R_in[R_WIDTH-1]}}, R_in};
    sum_ext = acc_ext + r_ext;
    if (sum_ext > ACC_MAX) begin
      sum_sat = {1'b0, {(ACC_WIDTH-1){1'b1}}};
    end else if (sum_ext < ACC_MIN) begin
      sum_sat = {1'b1, {(ACC_WIDTH-1){1'b0}}};
    end else begin
      sum_sat = sum_ext[ACC_WIDTH-1:0];
    end
  end

  // Next-state logic; abort overrides every transition outside IDLE.
  always_comb begin
    state_nx = state;
    if (abort && (state != S_IDLE)) begin
      state_nx = S_IDLE;
    end else begin
      case (state)
        S_IDLE:     if (start) state_nx = S_SENSE;
        S_SENSE:    state_nx = S_ACT;
        S_ACT:      if (act_ack) state_nx = S_HOLD;
        S_HOLD:     if (hold_cnt == '0) state_nx = S_RESAMPLE;
        S_RESAMPLE: state_nx = S_SETTLE;
        S_SETTLE:   state_nx = S_REWARD;
        S_REWARD:   state_nx = S_UPDATE;
        // The post-hold snapshot of one step serves as the pre-action
        // snapshot of the next, so a new step goes straight to ACT.
        S_UPDATE:   if (upd_done) state_nx = (step_inc == MAX_CNT) ? S_DONE : S_ACT;
        S_DONE:     state_nx = S_IDLE;
        default:    state_nx = S_IDLE;
      endcase
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state     <= S_IDLE;
      hold_cnt  <= '0;
      L0_s      <= '0;
      L1_s      <= '0;
      L2_s      <= '0;
      L3_s      <= '0;
      phase     <= '0;
      R_out     <= '0;
      step_cnt  <= '0;
      ep_reward <= '0;
    end else begin
      state <= state_nx;
      case (state)
        S_IDLE: begin
          if (start) begin
            step_cnt  <= '0;
            ep_reward <= '0;
          end
        end
        S_SENSE, S_RESAMPLE: begin
          if (!abort) begin
            L0_s <= L0;
            L1_s <= L1;
            L2_s <= L2;
            L3_s <= L3;
          end
        end
        S_ACT: begin
          if (!abort && act_ack) begin
            phase    <= action;
            hold_cnt <= HOLD_LOAD;
          end
        end
        S_HOLD: begin
          if (hold_cnt != '0) hold_cnt <= hold_cnt - HC_W'(1);
        end
        S_REWARD: begin
          if (!abort) begin
            R_out     <= R_in;
            ep_reward <= sum_sat;
          end
        end
        S_UPDATE: begin
          if (!abort && upd_done) step_cnt <= step_inc;
        end
        default: ;
      endcase
    end
  end

  assign act_req      = (state == S_ACT);
  assign upd_req      = (state == S_UPDATE);
  assign busy         = (state != S_IDLE);
  assign episode_done = (state == S_DONE);
  assign state_dbg    = state;

endmodule

// File: tb/tb_rl_step_sequencer.sv
// Bench for rl_step_sequencer: two instances, one single-step episode
// (default widths) and one 4-step episode with an 8-bit accumulator for
// saturation. Each instance has a small reward-decider model that registers
// a reward from the level snapshot one cycle later.

module tb_rl_step_sequencer;

  localparam logic [3:0] S_IDLE   = 4'd0;
  localparam logic [3:0] S_SENSE  = 4'd1;
  localparam logic [3:0] S_ACT    = 4'd2;
  localparam logic [3:0] S_HOLD   = 4'd3;
  localparam logic [3:0] S_UPDATE = 4'd7;
  localparam logic [3:0] S_DONE   = 4'd8;

  logic clk = 1'b0;
  logic rst = 1'b1;
  always #5 clk = ~clk;

  logic [3:0] L0 = '0, L1 = '0, L2 = '0, L3 = '0;
  logic       abort = 1'b0, act_ack = 1'b0, upd_done = 1'b0;
  logic [1:0] action = '0;
  logic       a_start = 1'b0, b_start = 1'b0;
  logic signed [15:0] rd_b = '0;

  // instance a: MAX_STEPS=1, ACC_WIDTH=24
  logic [3:0]         a_L0_s, a_L1_s, a_L2_s, a_L3_s;
  logic               a_act_req, a_upd_req, a_busy, a_episode_done;
  logic [1:0]         a_phase;
  logic signed [15:0] a_R_in = '0;
  logic signed [15:0] a_R_out;
  logic [7:0]         a_step_cnt;
  logic signed [23:0] a_ep_reward;
  logic [3:0]         a_state;

  // instance b: MAX_STEPS=4, ACC_WIDTH=8
  logic [3:0]         b_L0_s, b_L1_s, b_L2_s, b_L3_s;
  logic               b_act_req, b_upd_req, b_busy, b_episode_done;
  logic [1:0]         b_phase;
  logic signed [15:0] b_R_in = '0;
  logic signed [15:0] b_R_out;
  logic [7:0]         b_step_cnt;
  logic signed [7:0]  b_ep_reward;
  logic [3:0]         b_state;

  rl_step_sequencer #(.ACC_WIDTH(24), .HOLD_CYCLES(8), .MAX_STEPS(1)) dut_a (
    .clk(clk), .rst(rst), .start(a_start), .abort(abort),
    .L0(L0), .L1(L1), .L2(L2), .L3(L3),
    .L0_s(a_L0_s), .L1_s(a_L1_s), .L2_s(a_L2_s), .L3_s(a_L3_s),
    .act_req(a_act_req), .act_ack(act_ack), .action(action), .phase(a_phase),
    .R_in(a_R_in), .R_out(a_R_out), .upd_req(a_upd_req), .upd_done(upd_done),
    .step_cnt(a_step_cnt), .ep_reward(a_ep_reward), .busy(a_busy),
    .episode_done(a_episode_done), .state_dbg(a_state)
  );

  rl_step_sequencer #(.ACC_WIDTH(8), .HOLD_CYCLES(8), .MAX_STEPS(4)) dut_b (
    .clk(clk), .rst(rst), .start(b_start), .abort(abort),
    .L0(L0), .L1(L1), .L2(L2), .L3(L3),
    .L0_s(b_L0_s), .L1_s(b_L1_s), .L2_s(b_L2_s), .L3_s(b_L3_s),
    .act_req(b_act_req), .act_ack(act_ack), .action(action), .phase(b_phase),
    .R_in(b_R_in), .R_out(b_R_out), .upd_req(b_upd_req), .upd_done(upd_done),
    .step_cnt(b_step_cnt), .ep_reward(b_ep_reward), .busy(b_busy),
    .episode_done(b_episode_done), .state_dbg(b_state)
  );

  // Reward decider models: +40 for an all-empty snapshot, else level sum.
  always @(posedge clk) begin
    if ({a_L0_s, a_L1_s, a_L2_s, a_L3_s} == 16'h0000)
      a_R_in <= 16'sd40;
    else
      a_R_in <= 16'(a_L0_s) + 16'(a_L1_s) + 16'(a_L2_s) + 16'(a_L3_s);
    b_R_in <= rd_b;
  end

  int n_cmp = 0;
  int n_bad = 0;

  task automatic tick;
    @(posedge clk);
    #1;
  endtask

  task automatic test_reset;
    action = 2'd2; act_ack = 1'b1; upd_done = 1'b1;
    a_start = 1'b1; tick; a_start = 1'b0;
    tick; tick; tick;
    n_cmp++;
    if (a_phase !== 2'd2) begin
      n_bad++; $display("FAIL reset_pre_phase: got %0d expected 2", a_phase);
    end
    #3 rst = 1'b1;
    #1;
    n_cmp++;
    if ({a_L0_s, a_L1_s, a_L2_s, a_L3_s, a_phase, a_R_out, a_step_cnt, a_ep_reward,
         a_act_req, a_upd_req, a_busy, a_episode_done} !== '0) begin
      n_bad++; $display("FAIL reset_a_outputs: got %h expected 0",
        {a_L0_s, a_L1_s, a_L2_s, a_L3_s, a_phase, a_R_out, a_step_cnt, a_ep_reward,
         a_act_req, a_upd_req, a_busy, a_episode_done});
    end
    n_cmp++;
    if (a_state !== S_IDLE) begin
      n_bad++; $display("FAIL reset_a_state: got %0d expected %0d", a_state, S_IDLE);
    end
    n_cmp++;
    if ({b_phase, b_R_out, b_step_cnt, b_ep_reward, b_act_req, b_upd_req,
         b_busy, b_episode_done} !== '0) begin
      n_bad++; $display("FAIL reset_b_outputs: got %h expected 0",
        {b_phase, b_R_out, b_step_cnt, b_ep_reward, b_act_req, b_upd_req,
         b_busy, b_episode_done});
    end
    #1 rst = 1'b0;
    act_ack = 1'b0; upd_done = 1'b0;
    for (int i = 0; i < 20; i++) begin
      tick;
      n_cmp++;
      if ({a_act_req, a_upd_req, a_busy, b_act_req, b_upd_req, b_busy} !== 6'b0) begin
        n_bad++; $display("FAIL idle_quiet cycle %0d: got %b expected 000000", i,
          {a_act_req, a_upd_req, a_busy, b_act_req, b_upd_req, b_busy});
      end
    end
  endtask

  task automatic test_single_step;
    int hold2;
    int pulses;
    int done_at;
    hold2 = 0; pulses = 0; done_at = -1;
    L0 = 0; L1 = 0; L2 = 0; L3 = 0;
    action = 2'd2; act_ack = 1'b1; upd_done = 1'b1;
    a_start = 1'b1; tick; a_start = 1'b0;
    n_cmp++;
    if (a_phase !== 2'd0 || a_busy !== 1'b1) begin
      n_bad++; $display("FAIL single_pre: phase %0d busy %b expected 0 1", a_phase, a_busy);
    end
    for (int n = 1; n <= 20; n++) begin
      tick;
      if (a_state == S_HOLD && a_phase == 2'd2) hold2++;
      if (a_episode_done) begin
        pulses++;
        if (done_at < 0) done_at = n;
      end
    end
    act_ack = 1'b0; upd_done = 1'b0;
    n_cmp++;
    if (hold2 !== 8) begin n_bad++; $display("FAIL single_hold: got %0d expected 8", hold2); end
    n_cmp++;
    if (pulses !== 1) begin n_bad++; $display("FAIL single_pulses: got %0d expected 1", pulses); end
    n_cmp++;
    if (done_at !== 14) begin n_bad++; $display("FAIL single_latency: got %0d expected 14", done_at); end
    n_cmp++;
    if (a_R_out !== 16'sd40) begin n_bad++; $display("FAIL single_R_out: got %0d expected 40", a_R_out); end
    n_cmp++;
    if (a_ep_reward !== 24'sd40) begin n_bad++; $display("FAIL single_ep_reward: got %0d expected 40", a_ep_reward); end
    n_cmp++;
    if (a_step_cnt !== 8'd1) begin n_bad++; $display("FAIL single_step_cnt: got %0d expected 1", a_step_cnt); end
    n_cmp++;
    if (a_phase !== 2'd2 || a_busy !== 1'b0) begin
      n_bad++; $display("FAIL single_end: phase %0d busy %b expected 2 0", a_phase, a_busy);
    end
  endtask

  task automatic test_stall;
    L0 = 4'd1; L1 = 4'd2; L2 = 4'd3; L3 = 4'd4;
    action = 2'd1; act_ack = 1'b0; upd_done = 1'b0;
    a_start = 1'b1; tick; a_start = 1'b0;
    tick;
    n_cmp++;
    if ({a_L3_s, a_L2_s, a_L1_s, a_L0_s} !== 16'h4321) begin
      n_bad++; $display("FAIL stall_snapshot: got %h expected 4321", {a_L3_s, a_L2_s, a_L1_s, a_L0_s});
    end
    for (int i = 0; i < 5; i++) begin
      tick;
      n_cmp++;
      if (a_act_req !== 1'b1 || a_phase === 2'd1 || a_state !== S_ACT || a_step_cnt !== 8'd0) begin
        n_bad++; $display("FAIL stall_act cycle %0d: req %b phase %0d state %0d cnt %0d expected 1 !1 %0d 0",
          i, a_act_req, a_phase, a_state, a_step_cnt, S_ACT);
      end
    end
    act_ack = 1'b1; tick; act_ack = 1'b0;
    n_cmp++;
    if (a_phase !== 2'd1 || a_act_req !== 1'b0) begin
      n_bad++; $display("FAIL stall_ack: phase %0d req %b expected 1 0", a_phase, a_act_req);
    end
    L0 = 4'd5; L1 = 4'd6; L2 = 4'd7; L3 = 4'd8;
    repeat (11) tick;
    n_cmp++;
    if ({a_L3_s, a_L2_s, a_L1_s, a_L0_s} !== 16'h8765) begin
      n_bad++; $display("FAIL stall_resample: got %h expected 8765", {a_L3_s, a_L2_s, a_L1_s, a_L0_s});
    end
    n_cmp++;
    if (a_R_out !== 16'sd26 || a_ep_reward !== 24'sd26) begin
      n_bad++; $display("FAIL stall_reward: R_out %0d ep %0d expected 26 26", a_R_out, a_ep_reward);
    end
    for (int i = 0; i < 3; i++) begin
      n_cmp++;
      if (a_upd_req !== 1'b1 || a_step_cnt !== 8'd0 || a_episode_done !== 1'b0) begin
        n_bad++; $display("FAIL stall_upd cycle %0d: req %b cnt %0d done %b expected 1 0 0",
          i, a_upd_req, a_step_cnt, a_episode_done);
      end
      tick;
    end
    upd_done = 1'b1; tick; upd_done = 1'b0;
    n_cmp++;
    if (a_step_cnt !== 8'd1 || a_episode_done !== 1'b1 || a_upd_req !== 1'b0) begin
      n_bad++; $display("FAIL stall_done: cnt %0d done %b req %b expected 1 1 0",
        a_step_cnt, a_episode_done, a_upd_req);
    end
    tick;
    n_cmp++;
    if (a_busy !== 1'b0) begin n_bad++; $display("FAIL stall_idle: busy %b expected 0", a_busy); end
    L0 = 0; L1 = 0; L2 = 0; L3 = 0;
  endtask

  task automatic test_saturation(input logic signed [15:0] r,
                                 input logic signed [7:0] e0, input logic signed [7:0] e1,
                                 input logic signed [7:0] e2, input logic signed [7:0] e3);
    logic signed [7:0] got [4];
    logic signed [7:0] exp_v [4];
    int k;
    int pulses;
    exp_v[0] = e0; exp_v[1] = e1; exp_v[2] = e2; exp_v[3] = e3;
    k = 0; pulses = 0;
    for (int i = 0; i < 4; i++) got[i] = '0;
    rd_b = r; action = 2'd0; act_ack = 1'b1; upd_done = 1'b1;
    b_start = 1'b1; tick; b_start = 1'b0;
    for (int n = 1; n <= 70; n++) begin
      tick;
      if (b_upd_req) begin
        if (k < 4) got[k] = b_ep_reward;
        k++;
      end
      if (b_episode_done) pulses++;
    end
    act_ack = 1'b0; upd_done = 1'b0;
    n_cmp++;
    if (k !== 4) begin n_bad++; $display("FAIL sat_steps (r=%0d): got %0d expected 4", r, k); end
    for (int i = 0; i < 4; i++) begin
      n_cmp++;
      if (got[i] !== exp_v[i]) begin
        n_bad++; $display("FAIL sat_ep_reward[%0d] (r=%0d): got %0d expected %0d", i, r, got[i], exp_v[i]);
      end
    end
    n_cmp++;
    if (pulses !== 1 || b_step_cnt !== 8'd4 || b_R_out !== r) begin
      n_bad++; $display("FAIL sat_end (r=%0d): pulses %0d cnt %0d R_out %0d expected 1 4 %0d",
        r, pulses, b_step_cnt, b_R_out, r);
    end
  endtask

  task automatic test_abort;
    int n;
    int pulses;
    int done_at;
    rd_b = 16'sd5; action = 2'd2; act_ack = 1'b1; upd_done = 1'b1;
    b_start = 1'b1; tick; b_start = 1'b0;
    n = 0;
    while (!(b_state === S_HOLD && b_step_cnt === 8'd2) && n < 60) begin
      tick; n++;
    end
    n_cmp++;
    if (!(b_state === S_HOLD && b_step_cnt === 8'd2)) begin
      n_bad++; $display("FAIL abort_reach: state %0d cnt %0d expected %0d 2", b_state, b_step_cnt, S_HOLD);
    end
    tick; tick;
    abort = 1'b1; tick; abort = 1'b0;
    n_cmp++;
    if (b_state !== S_IDLE || b_busy !== 1'b0 || b_act_req !== 1'b0 || b_upd_req !== 1'b0) begin
      n_bad++; $display("FAIL abort_idle: state %0d busy %b act %b upd %b expected 0 0 0 0",
        b_state, b_busy, b_act_req, b_upd_req);
    end
    n_cmp++;
    if (b_step_cnt !== 8'd2 || b_ep_reward !== 8'sd10 || b_phase !== 2'd2) begin
      n_bad++; $display("FAIL abort_hold: cnt %0d ep %0d phase %0d expected 2 10 2",
        b_step_cnt, b_ep_reward, b_phase);
    end
    pulses = (b_episode_done === 1'b1) ? 1 : 0;
    for (int i = 0; i < 5; i++) begin
      tick;
      if (b_episode_done !== 1'b0) pulses++;
    end
    n_cmp++;
    if (pulses !== 0) begin n_bad++; $display("FAIL abort_no_done: got %0d pulses expected 0", pulses); end
    action = 2'd3;
    b_start = 1'b1; tick; b_start = 1'b0;
    n_cmp++;
    if (b_step_cnt !== 8'd0 || b_ep_reward !== 8'sd0) begin
      n_bad++; $display("FAIL abort_restart_clear: cnt %0d ep %0d expected 0 0", b_step_cnt, b_ep_reward);
    end
    pulses = 0; done_at = -1;
    for (int k = 1; k <= 60; k++) begin
      tick;
      if (b_episode_done) begin
        pulses++;
        if (done_at < 0) done_at = k;
      end
    end
    act_ack = 1'b0; upd_done = 1'b0;
    n_cmp++;
    if (pulses !== 1 || done_at !== 53) begin
      n_bad++; $display("FAIL abort_rerun_len: pulses %0d at %0d expected 1 at 53", pulses, done_at);
    end
    n_cmp++;
    if (b_step_cnt !== 8'd4 || b_ep_reward !== 8'sd20 || b_phase !== 2'd3) begin
      n_bad++; $display("FAIL abort_rerun_end: cnt %0d ep %0d phase %0d expected 4 20 3",
        b_step_cnt, b_ep_reward, b_phase);
    end
  endtask

  task automatic test_spurious;
    int act_wait;
    int pulses;
    int done_at;
    act_wait = 0; pulses = 0; done_at = -1;
    rd_b = 16'sd1; action = 2'd1; upd_done = 1'b1; act_ack = 1'b0;
    b_start = 1'b1; tick;
    for (int n = 1; n <= 75; n++) begin
      b_start = (b_state != S_IDLE) && (b_state != S_DONE);
      if (b_state == S_ACT) begin
        act_ack = (act_wait >= 2);
        act_wait++;
      end else begin
        act_ack = (b_state == S_HOLD);
        act_wait = 0;
      end
      upd_done = 1'b1;
      tick;
      if (b_episode_done) begin
        pulses++;
        if (done_at < 0) done_at = n;
      end
    end
    b_start = 1'b0; act_ack = 1'b0; upd_done = 1'b0;
    n_cmp++;
    if (pulses !== 1 || done_at !== 61) begin
      n_bad++; $display("FAIL spurious_len: pulses %0d at %0d expected 1 at 61", pulses, done_at);
    end
    n_cmp++;
    if (b_step_cnt !== 8'd4 || b_ep_reward !== 8'sd4 || b_phase !== 2'd1 || b_busy !== 1'b0) begin
      n_bad++; $display("FAIL spurious_end: cnt %0d ep %0d phase %0d busy %b expected 4 4 1 0",
        b_step_cnt, b_ep_reward, b_phase, b_busy);
    end
  endtask

  initial begin
    repeat (2) @(posedge clk);
    #1 rst = 1'b0;
    tick;
    test_reset;
    test_single_step;
    test_stall;
    test_saturation(16'sd100, 8'sd100, 8'sd127, 8'sd127, 8'sd127);
    test_saturation(-16'sd100, -8'sd100, -8'sd128, -8'sd128, -8'sd128);
    test_abort;
    test_spurious;
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
